// File: rtl/pc_trace_fifo.sv
// Bounded trace buffer for retired-instruction flow: stores {pc_current, pc_next, instr, disc}
// per retire and presents the oldest entry first-word-fallthrough on a valid/ready port.
module pc_trace_fifo #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PC_STEP   = 2,
  parameter int unsigned WRAP_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic                     cap_valid,
  input  logic [PC_W-1:0]          pc_current,
  input  logic [PC_W-1:0]          pc_next,
  input  logic [INSTR_W-1:0]       instr,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc_current,
  output logic [PC_W-1:0]          rd_pc_next,
  output logic [INSTR_W-1:0]       rd_instr,
  output logic                     rd_disc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 2 * PC_W + INSTR_W + 1;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic            push, pop, full_w, not_empty, disc, wr_en;
  logic [EW-1:0]   wr_entry, head;

  always_comb begin
    push      = cap_en & cap_valid;
    not_empty = (count_q != '0);
    pop       = not_empty & rd_ready;
    full_w    = (count_q == CW'(DEPTH));
    disc      = ((pc_current + PC_W'(PC_STEP)) != pc_next);
    wr_entry  = {disc, instr, pc_next, pc_current};
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (push && full_w && !pop) begin
      overflow_d = 1'b1;
      // Overwrite mode advances both pointers so the oldest entry is evicted.
      if (WRAP_MODE != 0) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + AW'(1);
        rptr_d = rptr_q + AW'(1);
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wptr_q] <= wr_entry;
    end
  end

  always_comb begin
    head          = not_empty ? mem[rptr_q] : '0;
    rd_valid      = not_empty;
    rd_pc_current = head[PC_W-1:0];
    rd_pc_next    = head[2*PC_W-1:PC_W];
    rd_instr      = head[2*PC_W+INSTR_W-1:2*PC_W];
    rd_disc       = head[EW-1];
    count         = count_q;
    full          = full_w;
    empty         = !not_empty;
    overflow      = overflow_q;
    drop_cnt      = drop_cnt_q;
  end

endmodule

// File: tb/tb_pc_trace_fifo.sv
// Bench for pc_trace_fifo: drop-mode and overwrite-mode instances share one stimulus stream,
// each checked every cycle against a queue model plus hand-computed literal expectations.
module tb_pc_trace_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clr = 1'b0, cap_en = 1'b0, cap_valid = 1'b0, rd_ready = 1'b0;
  logic [15:0] pc_current = '0, pc_next = '0, instr = '0;

  logic        rd_valid_o [2];
  logic [15:0] rd_pc_cur_o [2];
  logic [15:0] rd_pc_nxt_o [2];
  logic [15:0] rd_instr_o [2];
  logic        rd_disc_o [2];
  logic [4:0]  count_o [2];
  logic        full_o [2];
  logic        empty_o [2];
  logic        overflow_o [2];
  logic [7:0]  drop_o [2];

  always #5 clk = ~clk;

  pc_trace_fifo #(.PC_W(16), .INSTR_W(16), .DEPTH(DEPTH), .PC_STEP(2), .WRAP_MODE(0)) u_drop (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en), .cap_valid(cap_valid),
    .pc_current(pc_current), .pc_next(pc_next), .instr(instr), .rd_ready(rd_ready),
    .rd_valid(rd_valid_o[0]), .rd_pc_current(rd_pc_cur_o[0]), .rd_pc_next(rd_pc_nxt_o[0]),
    .rd_instr(rd_instr_o[0]), .rd_disc(rd_disc_o[0]), .count(count_o[0]), .full(full_o[0]),
    .empty(empty_o[0]), .overflow(overflow_o[0]), .drop_cnt(drop_o[0]));

  pc_trace_fifo #(.PC_W(16), .INSTR_W(16), .DEPTH(DEPTH), .PC_STEP(2), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en), .cap_valid(cap_valid),
    .pc_current(pc_current), .pc_next(pc_next), .instr(instr), .rd_ready(rd_ready),
    .rd_valid(rd_valid_o[1]), .rd_pc_current(rd_pc_cur_o[1]), .rd_pc_next(rd_pc_nxt_o[1]),
    .rd_instr(rd_instr_o[1]), .rd_disc(rd_disc_o[1]), .count(count_o[1]), .full(full_o[1]),
    .empty(empty_o[1]), .overflow(overflow_o[1]), .drop_cnt(drop_o[1]));

  // Model entry layout: {disc, instr, pc_next, pc_current}
  logic [48:0] mq [2][$];
  logic        m_ov [2];
  int          m_drop [2];
  bit          cmp_en = 1'b0;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic model_edge();
    logic [15:0] sum;
    logic [48:0] e;
    int          n;
    bit          do_push, do_pop;
    sum = pc_current + 16'd2;
    e = {(sum != pc_next), instr, pc_next, pc_current};
    for (int m = 0; m < 2; m++) begin
      if (rst || clr) begin
        mq[m].delete();
        m_ov[m] = 1'b0;
        m_drop[m] = 0;
      end else begin
        n = mq[m].size();
        do_push = cap_en && cap_valid;
        do_pop = (n > 0) && rd_ready;
        if (do_pop) void'(mq[m].pop_front());
        if (do_push) begin
          if (n == DEPTH && !do_pop) begin
            m_ov[m] = 1'b1;
            if (m == 1) begin
              void'(mq[m].pop_front());
              mq[m].push_back(e);
            end else if (m_drop[m] < 255) begin
              m_drop[m]++;
            end
          end else begin
            mq[m].push_back(e);
          end
        end
      end
    end
  endtask

  // Inputs set at negedge, model advanced right after the active edge.
  task automatic cyc(input bit en, input bit vld, input logic [15:0] pc, input logic [15:0] nxt,
                     input logic [15:0] ins, input bit rdy, input bit c, input bit r);
    cap_en = en; cap_valid = vld; pc_current = pc; pc_next = nxt; instr = ins;
    rd_ready = rdy; clr = c; rst = r;
    @(posedge clk);
    model_edge();
    cmp_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_only(input logic [15:0] pc, input logic [15:0] nxt, input logic [15:0] ins,
                           input bit rdy);
    cyc(1'b1, 1'b1, pc, nxt, ins, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, rdy, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 2; m++) begin
        logic [48:0] h;
        int          n;
        n = mq[m].size();
        h = (n > 0) ? mq[m][0] : '0;
        chk($sformatf("m%0d.count", m), 32'(count_o[m]), 32'(n));
        chk($sformatf("m%0d.rd_valid", m), 32'(rd_valid_o[m]), 32'(n > 0));
        chk($sformatf("m%0d.empty", m), 32'(empty_o[m]), 32'(n == 0));
        chk($sformatf("m%0d.full", m), 32'(full_o[m]), 32'(n == DEPTH));
        chk($sformatf("m%0d.overflow", m), 32'(overflow_o[m]), 32'(m_ov[m]));
        chk($sformatf("m%0d.drop_cnt", m), 32'(drop_o[m]), 32'(m_drop[m]));
        chk($sformatf("m%0d.rd_pc_current", m), 32'(rd_pc_cur_o[m]), 32'(h[15:0]));
        chk($sformatf("m%0d.rd_pc_next", m), 32'(rd_pc_nxt_o[m]), 32'(h[31:16]));
        chk($sformatf("m%0d.rd_instr", m), 32'(rd_instr_o[m]), 32'(h[47:32]));
        chk($sformatf("m%0d.rd_disc", m), 32'(rd_disc_o[m]), 32'(h[48]));
      end
    end
  end

  initial begin
    logic [15:0] pc;
    @(negedge clk);
    cyc(1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("reset.empty", 32'(empty_o[0]), 32'd1);
    chk("reset.count", 32'(count_o[0]), 32'd0);
    chk("reset.rd_valid", 32'(rd_valid_o[1]), 32'd0);
    chk("reset.rd_instr", 32'(rd_instr_o[1]), 32'd0);

    // T1 / T2: sequential, jump, and wrap-around sequential entries
    push_only(16'h0000, 16'h0002, 16'h1234, 1'b0);
    chk("t1.rd_valid", 32'(rd_valid_o[0]), 32'd1);
    chk("t1.count", 32'(count_o[0]), 32'd1);
    chk("t1.rd_disc", 32'(rd_disc_o[0]), 32'd0);
    chk("t1.rd_instr", 32'(rd_instr_o[0]), 32'h1234);
    push_only(16'h0010, 16'h0040, 16'hA000, 1'b0);
    push_only(16'hFFFE, 16'h0000, 16'hB000, 1'b0);
    idle(1'b1);
    chk("t2.jump_disc", 32'(rd_disc_o[0]), 32'd1);
    chk("t2.jump_pc_next", 32'(rd_pc_nxt_o[0]), 32'h0040);
    idle(1'b1);
    chk("t2.wrap_disc", 32'(rd_disc_o[1]), 32'd0);
    chk("t2.wrap_pc_cur", 32'(rd_pc_cur_o[1]), 32'hFFFE);
    idle(1'b1);
    chk("t2.drained", 32'(empty_o[0]), 32'd1);

    // T3 / T4: 20 pushes into a 16-deep buffer, no pops
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      pc = 16'(i * 4);
      push_only(pc, (i % 3 == 0) ? pc + 16'd8 : pc + 16'd2, 16'hC000 + 16'(i), 1'b0);
    end
    chk("t3.full", 32'(full_o[0]), 32'd1);
    chk("t3.count", 32'(count_o[0]), 32'd16);
    chk("t3.overflow", 32'(overflow_o[0]), 32'd1);
    chk("t3.drop_cnt", 32'(drop_o[0]), 32'd4);
    chk("t3.head", 32'(rd_instr_o[0]), 32'hC001);
    chk("t4.count", 32'(count_o[1]), 32'd16);
    chk("t4.drop_cnt", 32'(drop_o[1]), 32'd0);
    chk("t4.overflow", 32'(overflow_o[1]), 32'd1);
    chk("t4.head", 32'(rd_instr_o[1]), 32'hC005);
    chk("t4.head_pc", 32'(rd_pc_cur_o[1]), 32'h0014);
    for (int i = 0; i < 15; i++) idle(1'b1);
    chk("t4.last", 32'(rd_instr_o[1]), 32'hC014);
    chk("t3.last", 32'(rd_instr_o[0]), 32'hC010);
    idle(1'b1);
    chk("t4.drained", 32'(empty_o[1]), 32'd1);

    // T5: full without prior overflow, then simultaneous push and pop
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) push_only(16'(i * 2), 16'(i * 2 + 2), 16'hD000 + 16'(i), 1'b0);
    push_only(16'h0100, 16'h0102, 16'hD011, 1'b1);
    chk("t5.count", 32'(count_o[0]), 32'd16);
    chk("t5.overflow", 32'(overflow_o[0]), 32'd0);
    chk("t5.head", 32'(rd_instr_o[0]), 32'hD002);
    chk("t5.wrap_overflow", 32'(overflow_o[1]), 32'd0);

    // Drop counter saturation and sustained overwrite
    for (int k = 0; k < 256; k++) push_only(16'h0200, 16'h0300, 16'hE000 + 16'(k), 1'b0);
    chk("sat.drop_cnt", 32'(drop_o[0]), 32'd255);
    chk("sat.drop_head", 32'(rd_instr_o[0]), 32'hD002);
    chk("sat.wrap_head", 32'(rd_instr_o[1]), 32'hE0F0);
    chk("sat.wrap_drop", 32'(drop_o[1]), 32'd0);

    // T6: drain to 3 entries, then clr together with push and ready
    for (int i = 0; i < 13; i++) idle(1'b1);
    chk("t6.pre_count", 32'(count_o[0]), 32'd3);
    cyc(1'b1, 1'b1, 16'h0400, 16'h0402, 16'hF000, 1'b1, 1'b1, 1'b0);
    chk("t6.empty", 32'(empty_o[0]), 32'd1);
    chk("t6.count", 32'(count_o[1]), 32'd0);
    chk("t6.drop_cnt", 32'(drop_o[0]), 32'd0);
    chk("t6.overflow", 32'(overflow_o[1]), 32'd0);

    // Capture gating, push into empty with ready high, reset and clr together mid-drain
    cyc(1'b0, 1'b1, 16'h0500, 16'h0502, 16'hF001, 1'b1, 1'b0, 1'b0);
    chk("gate.count", 32'(count_o[0]), 32'd0);
    push_only(16'h0600, 16'h0700, 16'hF002, 1'b1);
    chk("empty_push.count", 32'(count_o[0]), 32'd1);
    chk("empty_push.disc", 32'(rd_disc_o[1]), 32'd1);
    push_only(16'h0602, 16'h0604, 16'hF003, 1'b1);
    cyc(1'b1, 1'b1, 16'h0604, 16'h0606, 16'hF004, 1'b1, 1'b1, 1'b1);
    chk("rst.rd_valid", 32'(rd_valid_o[0]), 32'd0);
    idle(1'b0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
